// File: rtl/ptm_server.sv
// ptm_server: text memory server for a pattern matcher.
// Words are loaded into memory, then served to the matcher on request.
// Match flags are collected per address, and the final result is latched.
// Optional macro PTM_SERVER_EXPECT_EN stores each word's expected flag and
// counts the requests whose flag differs from it (err_cnt).
module ptm_server #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [10:0]      load_data,
  output logic             load_ready,
  input  logic             clear,
  output logic             start,
  input  logic             en,
  input  logic [9:0]       addr,
  output logic [9:0]       data,
  input  logic             flag,
  input  logic             fin,
  input  logic [9:0]       result,
  output logic [9:0]       result_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             oor_err,
  output logic             done
);

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 10;
`ifdef PTM_SERVER_EXPECT_EN
  localparam int unsigned MW = 11;
`else
  localparam int unsigned MW = 10;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state;
  logic [AW-1:0]    wptr;
  logic [DEPTH-1:0] map;
  logic [MW-1:0]    mem [DEPTH];
  logic             loading;
  logic             in_range;
  logic             sample;

  assign loading  = (state == IDLE) || (state == LOAD);
  assign in_range = 32'(addr) < DEPTH;
  assign sample   = (state == RUN) && en && in_range;

  // Combinational read port toward the matcher
  assign data = sample ? mem[addr][MW-1 -: DW] : '0;

  // Text memory write port; contents survive reset and clear
  always_ff @(posedge clk) begin
    if (loading && load_valid) begin
      mem[wptr] <= load_data[10 -: MW];
    end
  end

  // Control FSM with registered handshake outputs, match map and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wptr       <= '0;
      map        <= '0;
      match_cnt  <= '0;
      oor_err    <= 1'b0;
      result_q   <= '0;
      done       <= 1'b0;
      start      <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (load_valid) begin
            if (wptr == AW'(DEPTH - 1)) begin
              state      <= RUN;
              load_ready <= 1'b0;
              start      <= 1'b1;
            end else begin
              wptr  <= wptr + AW'(1);
              state <= LOAD;
            end
          end
        end
        RUN: begin
          if (sample && flag && !map[addr]) begin
            map[addr] <= 1'b1;
            if (match_cnt != '1) begin
              match_cnt <= match_cnt + CNT_W'(1);
            end
          end
          if (en && !in_range) begin
            oor_err <= 1'b1;
          end
          if (fin) begin
            result_q <= result;
            state    <= DONE;
            start    <= 1'b0;
            done     <= 1'b1;
          end
        end
        DONE: begin
          if (clear) begin
            state      <= IDLE;
            wptr       <= '0;
            map        <= '0;
            match_cnt  <= '0;
            oor_err    <= 1'b0;
            result_q   <= '0;
            done       <= 1'b0;
            load_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PTM_SERVER_EXPECT_EN
  // Saturating count of sampled flags that disagree with the stored expectation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if ((state == DONE) && clear) begin
      err_cnt <= '0;
    end else if (sample && (flag != mem[addr][0]) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_expect;

  // Expected-flag bit is not stored in this build
  assign unused_expect = load_data[0];
  assign err_cnt       = '0;
`endif

endmodule

// File: tb/tb_ptm_server.sv
// Directed bench for ptm_server: DEPTH=1024 instance (a) and DEPTH=1000
// instance (b) share all stimulus; expectations are hand-computed.
module tb_ptm_server;

`ifdef PTM_SERVER_EXPECT_EN
  localparam int EXP = 1;
`else
  localparam int EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic [10:0] load_data = '0;
  logic        clear = 1'b0;
  logic        en = 1'b0;
  logic [9:0]  addr = '0;
  logic        flag = 1'b0;
  logic        fin = 1'b0;
  logic [9:0]  result = '0;

  logic        load_ready_a, start_a, oor_a, done_a;
  logic [9:0]  data_a, result_q_a;
  logic [10:0] match_a, err_a;
  logic        load_ready_b, start_b, oor_b, done_b;
  logic [9:0]  data_b, result_q_b;
  logic [10:0] match_b, err_b;

  int total = 0;
  int bad   = 0;

  ptm_server u_dut_a (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready_a), .clear(clear), .start(start_a), .en(en),
    .addr(addr), .data(data_a), .flag(flag), .fin(fin), .result(result),
    .result_q(result_q_a), .match_cnt(match_a), .err_cnt(err_a),
    .oor_err(oor_a), .done(done_a)
  );

  ptm_server #(.DEPTH(1000)) u_dut_b (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready_b), .clear(clear), .start(start_b), .en(en),
    .addr(addr), .data(data_b), .flag(flag), .fin(fin), .result(result),
    .result_q(result_q_b), .match_cnt(match_b), .err_cnt(err_b),
    .oor_err(oor_b), .done(done_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] word(input int i);
    return (i == 5) ? 10'h3A5 : 10'(i * 7 + 3);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("rst_load_ready", 32'(load_ready_a), 32'd1);
    check("rst_start", 32'(start_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_match", 32'(match_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_oor", 32'(oor_a), 32'd0);
    check("rst_result_q", 32'(result_q_a), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // partial load, then asynchronous reset mid-LOAD
    for (int i = 0; i < 300; i++) begin
      load_valid = 1'b1;
      load_data  = {word(i), 1'(i == 5)};
      tick();
    end
    load_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midload_rst_ready", 32'(load_ready_a), 32'd1);
    check("midload_rst_start", 32'(start_a), 32'd0);
    #2 rst = 1'b1;
    tick();

    // full reload must need all DEPTH words again
    for (int i = 0; i < 1024; i++) begin
      load_valid = 1'b1;
      load_data  = {word(i), 1'(i == 5)};
      tick();
      if (i == 998) check("b_start_before_last", 32'(start_b), 32'd0);
      if (i == 999) check("b_start_after_last", 32'(start_b), 32'd1);
      if (i == 1022) begin
        check("a_start_before_last", 32'(start_a), 32'd0);
        check("a_ready_before_last", 32'(load_ready_a), 32'd1);
      end
    end
    check("a_start_run", 32'(start_a), 32'd1);
    check("a_ready_run", 32'(load_ready_a), 32'd0);
    check("b_ready_run", 32'(load_ready_b), 32'd0);
    load_valid = 1'b0;

    // combinational read port
    en = 1'b1; addr = 10'd5; #1;
    check("data_a_5", 32'(data_a), 32'h3A5);
    check("data_b_5", 32'(data_b), 32'h3A5);
    addr = 10'd7; #1;
    check("data_a_7", 32'(data_a), 32'h034);
    en = 1'b0; #1;
    check("data_a_en0", 32'(data_a), 32'd0);

    // clear ignored in RUN
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_ign_start", 32'(start_a), 32'd1);
    check("clear_ign_done", 32'(done_a), 32'd0);

    // flags: addr 5 twice, then addr 7
    en = 1'b1; flag = 1'b1; addr = 10'd5;
    tick();
    tick();
    addr = 10'd7;
    tick();
    en = 1'b0; flag = 1'b0;
    check("match_a_2", 32'(match_a), 32'd2);
    check("match_b_2", 32'(match_b), 32'd2);
    check("err_a_1", 32'(err_a), 32'(EXP));

    // addr 1010: out of range for b, in range for a
    en = 1'b1; flag = 1'b1; addr = 10'd1010; #1;
    check("data_a_1010", 32'(data_a), 32'h3A1);
    check("data_b_oor", 32'(data_b), 32'd0);
    tick();
    en = 1'b0; flag = 1'b0;
    check("oor_b", 32'(oor_b), 32'd1);
    check("match_b_oor", 32'(match_b), 32'd2);
    check("oor_a", 32'(oor_a), 32'd0);
    check("match_a_3", 32'(match_a), 32'd3);
    check("err_a_2", 32'(err_a), 32'(2 * EXP));
    check("err_b_1", 32'(err_b), 32'(EXP));

    // fin with a same-cycle flag at addr 9
    en = 1'b1; flag = 1'b1; addr = 10'd9; fin = 1'b1; result = 10'd2;
    tick();
    en = 1'b0; flag = 1'b0; fin = 1'b0; result = 10'd0;
    check("result_q_a", 32'(result_q_a), 32'd2);
    check("result_q_b", 32'(result_q_b), 32'd2);
    check("match_a_fin", 32'(match_a), 32'd4);
    check("match_b_fin", 32'(match_b), 32'd3);
    check("err_a_fin", 32'(err_a), 32'(3 * EXP));
    check("done_a", 32'(done_a), 32'd1);
    check("done_b", 32'(done_b), 32'd1);
    check("start_a_done", 32'(start_a), 32'd0);

    // DONE ignores requests and loads
    en = 1'b1; flag = 1'b1; addr = 10'd11; load_valid = 1'b1;
    tick();
    en = 1'b0; flag = 1'b0; load_valid = 1'b0;
    check("done_hold_match", 32'(match_a), 32'd4);
    check("done_hold_ready", 32'(load_ready_a), 32'd0);
    check("done_hold_result", 32'(result_q_a), 32'd2);

    // clear returns to IDLE
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_done", 32'(done_a), 32'd0);
    check("clr_match", 32'(match_a), 32'd0);
    check("clr_err", 32'(err_a), 32'd0);
    check("clr_oor_b", 32'(oor_b), 32'd0);
    check("clr_result_q", 32'(result_q_a), 32'd0);
    check("clr_ready", 32'(load_ready_a), 32'd1);
    check("clr_start", 32'(start_a), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
